// File: rtl/tile_sched.sv
// tile_sched: raster tracker and tile colour resolver over a double-buffered tile table; 2 cen-cycle latency.
// Config port is held off (ready low) while a commit waits for frame start. Define TILE_SCHED_BORDER_EN to draw tile borders in colour 3.
module tile_sched #(
  parameter int NUM_TILES = 8,
  parameter int H_ACTIVE  = 1920,
  parameter int V_OFFSET  = 46,
  parameter int V_ACTIVE  = 1080
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cen_i,
  input  logic [3:0]  fvht_i,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic [3:0]  cfg_idx_i,
  input  logic [14:0] cfg_data_i,
  input  logic        commit_i,
  output logic        commit_pending_o,
  output logic        frame_start_o,
  output logic        active_o,
  output logic [1:0]  colour_sel_o,
  output logic [3:0]  fvht_o
);

  typedef struct packed {
    logic       en;
    logic [1:0] colour;
    logic [5:0] col;
    logic [5:0] row;
  } tile_t;

  typedef struct packed {
    logic [1:0] gran;
    logic [1:0] bg;
  } glob_t;

  localparam logic [11:0] H_LIM    = 12'(H_ACTIVE);
  localparam logic [11:0] V_LO     = 12'(V_OFFSET);
  localparam logic [11:0] V_HI     = 12'(V_OFFSET + V_ACTIVE);
  localparam glob_t       GLOB_RST = '{gran: 2'd1, bg: 2'd0};

  tile_t       shd_tile [NUM_TILES];
  tile_t       act_tile [NUM_TILES];
  glob_t       shd_glob;
  glob_t       act_glob;
  logic        pending;

  logic        prev_h;
  logic        prev_v;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic [11:0] hcount_n;
  logic [11:0] vcount_n;
  logic [6:0]  px_sub;
  logic [6:0]  ln_sub;
  logic [6:0]  px_sub_n;
  logic [6:0]  ln_sub_n;
  logic [5:0]  col;
  logic [5:0]  row;
  logic [5:0]  col_n;
  logic [5:0]  row_n;
  logic [3:0]  fvht_s1;
  logic        fs_s1;

  logic        h_fall;
  logic        v_rise;
  logic        line_act;
  logic        fs_apply;
  logic        cfg_we;
  logic [6:0]  size;

  function automatic logic [6:0] pitch(input logic [1:0] g);
    case (g)
      2'd0:    return 7'd120;
      2'd1:    return 7'd60;
      2'd2:    return 7'd40;
      default: return 7'd30;
    endcase
  endfunction

  assign size             = pitch(act_glob.gran);
  assign h_fall           = prev_h & ~fvht_i[1];
  assign v_rise           = fvht_i[2] & ~prev_v;
  assign line_act         = (vcount >= V_LO) && (vcount < V_HI);
  assign fs_apply         = pending & v_rise & cen_i;
  assign cfg_we           = cfg_valid_i & ~pending;
  assign cfg_ready_o      = ~pending;
  assign commit_pending_o = pending;

  // Raster and tile sub-counters; frame start overrides everything vertical.
  always_comb begin
    hcount_n = hcount;
    vcount_n = vcount;
    px_sub_n = px_sub;
    ln_sub_n = ln_sub;
    col_n    = col;
    row_n    = row;
    if (h_fall) begin
      hcount_n = 12'd0;
      vcount_n = vcount + 12'd1;
      px_sub_n = 7'd0;
      col_n    = 6'd0;
      if (line_act) begin
        if (ln_sub == size - 7'd1) begin
          ln_sub_n = 7'd0;
          row_n    = row + 6'd1;
        end else begin
          ln_sub_n = ln_sub + 7'd1;
        end
      end
    end else if (!fvht_i[1]) begin
      hcount_n = hcount + 12'd1;
      if (px_sub == size - 7'd1) begin
        px_sub_n = 7'd0;
        col_n    = col + 6'd1;
      end else begin
        px_sub_n = px_sub + 7'd1;
      end
    end
    if (v_rise) begin
      vcount_n = 12'd0;
      ln_sub_n = 7'd0;
      row_n    = 6'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      prev_h  <= 1'b0;
      prev_v  <= 1'b1;   // no frame start until a genuine v-blank rising edge
      hcount  <= 12'd0;
      vcount  <= 12'd0;
      px_sub  <= 7'd0;
      ln_sub  <= 7'd0;
      col     <= 6'd0;
      row     <= 6'd0;
      fvht_s1 <= 4'd0;
      fs_s1   <= 1'b0;
    end else if (cen_i) begin
      prev_h  <= fvht_i[1];
      prev_v  <= fvht_i[2];
      hcount  <= hcount_n;
      vcount  <= vcount_n;
      px_sub  <= px_sub_n;
      ln_sub  <= ln_sub_n;
      col     <= col_n;
      row     <= row_n;
      fvht_s1 <= fvht_i;
      fs_s1   <= v_rise;
    end
  end

  logic       act_s2;
  logic       hit;
  logic [1:0] tile_col;
  logic [1:0] colour_n;

  // Descending scan so the lowest matching index is the last writer.
  always_comb begin
    act_s2   = ~fvht_s1[1] && (hcount < H_LIM) && line_act;
    hit      = 1'b0;
    tile_col = 2'd0;
    for (int i = NUM_TILES - 1; i >= 0; i--) begin
      if (act_tile[i].en && act_tile[i].col == col && act_tile[i].row == row) begin
        hit      = 1'b1;
        tile_col = act_tile[i].colour;
      end
    end
`ifdef TILE_SCHED_BORDER_EN
    if (hit && (px_sub == 7'd0 || px_sub == size - 7'd1 ||
                ln_sub == 7'd0 || ln_sub == size - 7'd1)) begin
      tile_col = 2'd3;
    end
`endif
    if (!act_s2) begin
      colour_n = 2'd0;
    end else if (hit) begin
      colour_n = tile_col;
    end else begin
      colour_n = act_glob.bg;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      active_o      <= 1'b0;
      colour_sel_o  <= 2'd0;
      fvht_o        <= 4'd0;
      frame_start_o <= 1'b0;
    end else if (cen_i) begin
      active_o      <= act_s2;
      colour_sel_o  <= colour_n;
      fvht_o        <= fvht_s1;
      frame_start_o <= fs_s1;
    end
  end

  // Shadow table: host writes are independent of the pixel clock enable.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_TILES; i++) shd_tile[i] <= '0;
      shd_glob <= GLOB_RST;
    end else if (cfg_we) begin
      if (cfg_idx_i == 4'hF) begin
        shd_glob <= glob_t'(cfg_data_i[3:0]);
      end
      for (int i = 0; i < NUM_TILES; i++) begin
        if (cfg_idx_i == 4'(i)) shd_tile[i] <= tile_t'(cfg_data_i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_TILES; i++) act_tile[i] <= '0;
      act_glob <= GLOB_RST;
    end else if (fs_apply) begin
      for (int i = 0; i < NUM_TILES; i++) act_tile[i] <= shd_tile[i];
      act_glob <= shd_glob;
    end
  end

  // Pending flag is registered, so a commit on the frame-start cycle waits a frame.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pending <= 1'b0;
    end else if (fs_apply) begin
      pending <= 1'b0;
    end else if (commit_i) begin
      pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tile_sched.sv
// Scoreboard bench for tile_sched on a reduced 64x64 raster (2 blank lines, 4 blank pixels per line).
module tb_tile_sched;
  localparam int NT = 8;
  localparam int HA = 64;
  localparam int HB = 4;
  localparam int HT = HA + HB;
  localparam int VO = 2;
  localparam int VA = 64;
  localparam int VB = 2;
  localparam int NL = VO + VA;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        cen_i = 1'b1;
  logic [3:0]  fvht_i = 4'b0010;
  logic        cfg_valid_i = 1'b0;
  logic        cfg_ready_o;
  logic [3:0]  cfg_idx_i = 4'd0;
  logic [14:0] cfg_data_i = 15'd0;
  logic        commit_i = 1'b0;
  logic        commit_pending_o;
  logic        frame_start_o;
  logic        active_o;
  logic [1:0]  colour_sel_o;
  logic [3:0]  fvht_o;

  tile_sched #(.NUM_TILES(NT), .H_ACTIVE(HA), .V_OFFSET(VO), .V_ACTIVE(VA)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .cen_i(cen_i), .fvht_i(fvht_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_idx_i(cfg_idx_i),
    .cfg_data_i(cfg_data_i), .commit_i(commit_i), .commit_pending_o(commit_pending_o),
    .frame_start_o(frame_start_o), .active_o(active_o), .colour_sel_o(colour_sel_o),
    .fvht_o(fvht_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit         chk;
    logic       act;
    logic [1:0] col;
    logic [3:0] fv;
    logic       fs;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          act_cnt = 0;
  int          frame_no = 0;
  logic [14:0] m_shd [NT];
  logic [14:0] m_act [NT];
  logic [3:0]  m_shd_g;
  logic [3:0]  m_act_g;
  bit          m_pend = 0;
  bit          synced = 0;
  bit          stall_mode = 0;

  function automatic void check(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endfunction

  // Reference uses direct division on the bench's own raster position.
  function automatic exp_t model(int l, int x, logic [3:0] fv, bit fs);
    exp_t e;
    int sz, y, c, r;
    bit hit;
    logic [1:0] tc;
    e.chk = synced;
    e.fv  = fv;
    e.fs  = fs;
    e.act = (fv[1] == 1'b0) && (x < HA) && (l >= VO) && (l < VO + VA);
    e.col = 2'd0;
    if (e.act) begin
      sz  = 120 / (int'(m_act_g[3:2]) + 1);
      y   = l - VO;
      c   = x / sz;
      r   = y / sz;
      hit = 0;
      tc  = 2'd0;
      for (int i = 0; i < NT; i++) begin
        if (!hit && m_act[i][14] && int'(m_act[i][11:6]) == c && int'(m_act[i][5:0]) == r) begin
          hit = 1;
          tc  = m_act[i][13:12];
        end
      end
`ifdef TILE_SCHED_BORDER_EN
      if (hit && ((x % sz) == 0 || (x % sz) == sz - 1 || (y % sz) == 0 || (y % sz) == sz - 1))
        tc = 2'd3;
`endif
      e.col = hit ? tc : m_act_g[1:0];
    end
    return e;
  endfunction

  task automatic step(input logic [3:0] fv, input bit c, input exp_t e);
    cen_i  = c;
    fvht_i = fv;
    if (c) q.push_back(e);
    @(negedge clk_i);
  endtask

  task automatic pix(input logic [3:0] fv, input exp_t e);
    if (stall_mode) step(fv, 1'b0, e);
    step(fv, 1'b1, e);
  endtask

  task automatic idle(input int n);
    logic [3:0] fv;
    fv = {frame_no[0], 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < n; i++) pix(fv, model(-1, 0, fv, 1'b0));
  endtask

  task automatic do_reset();
    exp_t z;
    z = '{chk: 1'b1, act: 1'b0, col: 2'd0, fv: 4'd0, fs: 1'b0};
    rst_n_i     = 1'b0;
    cfg_valid_i = 1'b0;
    commit_i    = 1'b0;
    q.delete();
    q.push_back(z);
    synced  = 0;
    m_pend  = 0;
    m_shd_g = 4'b0100;
    m_act_g = 4'b0100;
    for (int i = 0; i < NT; i++) begin
      m_shd[i] = '0;
      m_act[i] = '0;
    end
    @(negedge clk_i);
    check("rst_active_o", int'(active_o), 0);
    check("rst_colour_sel_o", int'(colour_sel_o), 0);
    check("rst_fvht_o", int'(fvht_o), 0);
    check("rst_frame_start_o", int'(frame_start_o), 0);
    check("rst_commit_pending_o", int'(commit_pending_o), 0);
    check("rst_cfg_ready_o", int'(cfg_ready_o), 1);
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic cfg_write(input logic [3:0] idx, input logic [14:0] d);
    check("cfg_ready_o", int'(cfg_ready_o), int'(!m_pend));
    cfg_valid_i = 1'b1;
    cfg_idx_i   = idx;
    cfg_data_i  = d;
    if (!m_pend) begin
      if (idx == 4'hF) m_shd_g = d[3:0];
      else if (int'(idx) < NT) m_shd[idx[2:0]] = d;
    end
    idle(1);
    cfg_valid_i = 1'b0;
  endtask

  task automatic commit();
    commit_i = 1'b1;
    idle(1);
    commit_i = 1'b0;
    m_pend   = 1;
    check("commit_pending_o_set", int'(commit_pending_o), 1);
    check("cfg_ready_o_pending", int'(cfg_ready_o), 0);
  endtask

  // commit_line 0 issues commit_i on the frame-start pixel itself.
  task automatic run_frame(input int commit_line, input int rst_line);
    logic [3:0] fv;
    bit fs, was_pend;
    for (int l = 0; l < NL; l++) begin
      for (int x = 0; x < HT; x++) begin
        fv = {frame_no[0], (l < VB), (x >= HA), 1'b0};
        fs = (l == 0 && x == 0);
        if (fs) begin
          synced = 1;
          if (m_pend) begin
            m_act   = m_shd;
            m_act_g = m_shd_g;
            m_pend  = 0;
          end
        end
        if (l == rst_line && x == 10) do_reset();
        if (l == commit_line && x == 0) begin
          was_pend = m_pend || fs && (commit_line == 0) && 1'b0;
          commit_i = 1'b1;
          if (!was_pend) m_pend = 1;
        end
        if (l == 30 && x == 0) begin
          check("pending_midframe", int'(commit_pending_o), int'(m_pend));
          check("ready_midframe", int'(cfg_ready_o), int'(!m_pend));
        end
        pix(fv, model(l, x, fv, fs));
        commit_i = 1'b0;
      end
    end
    frame_no++;
  endtask

  // Monitor: every enabled edge retires one scoreboard entry; stalled edges must hold outputs.
  initial begin
    exp_t e;
    logic c, r;
    logic [7:0] prev, cur;
    bit have_prev;
    have_prev = 0;
    prev = '0;
    forever begin
      @(posedge clk_i);
      c = cen_i;
      r = rst_n_i;
      #1;
      cur = {active_o, colour_sel_o, fvht_o, frame_start_o};
      if (!r || !rst_n_i) begin
        have_prev = 0;
      end else begin
        if (c) begin
          if (q.size() == 0) begin
            check("scoreboard_underflow", 1, 0);
          end else begin
            e = q.pop_front();
            check("fvht_o", int'(fvht_o), int'(e.fv));
            if (e.chk) begin
              check("active_o", int'(active_o), int'(e.act));
              check("colour_sel_o", int'(colour_sel_o), int'(e.col));
              check("frame_start_o", int'(frame_start_o), int'(e.fs));
            end
            if (active_o) act_cnt++;
          end
        end else if (have_prev) begin
          check("stall_hold", int'(cur), int'(prev));
        end
        prev = cur;
        have_prev = 1;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    idle(4);

    // Default tables: all active pixels colour 0, exactly HA*VA active.
    act_cnt = 0;
    run_frame(-1, -1);
    idle(4);
    check("active_count", act_cnt, HA * VA);

    // Single tile at (0,0), pitch 60.
    cfg_write(4'd0, 15'h6000);
    commit();
    run_frame(-1, -1);
    check("pending_cleared", int'(commit_pending_o), 0);

    // Pitch 30 plus tile (1,1) colour 1.
    cfg_write(4'hF, 15'h000C);
    cfg_write(4'd1, 15'h5041);
    commit();
    run_frame(-1, -1);

    // Overlapping idx2/idx5 on tile (2,0); lowest index wins. Background 1.
    cfg_write(4'd2, 15'h5080);
    cfg_write(4'd5, 15'h7080);
    cfg_write(4'hF, 15'h000D);
    cfg_write(4'd9, 15'h7FFF);
    commit();
    run_frame(-1, -1);

    // Commit on the frame-start cycle is deferred a whole frame; writes refused meanwhile.
    cfg_write(4'd3, 15'h7002);
    run_frame(0, -1);
    idle(2);
    check("pending_after_fs_commit", int'(commit_pending_o), 1);
    cfg_write(4'd4, 15'h7040);
    run_frame(-1, -1);
    check("pending_after_swap", int'(commit_pending_o), 0);

    // Stalled run, then a reset mid-line with a commit outstanding.
    stall_mode = 1;
    run_frame(-1, -1);
    cfg_write(4'd6, 15'h5000);
    run_frame(10, 20);
    run_frame(-1, -1);
    check("pending_after_reset", int'(commit_pending_o), 0);
    stall_mode = 0;

    // Defaults restored: pitch 60 after reset.
    cfg_write(4'd0, 15'h6000);
    commit();
    run_frame(-1, -1);
    idle(4);
    check("scoreboard_drain", q.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
